// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Owns the program counter, issues one word read at a time to instruction
// memory, buffers returned words (with their PCs) in a small FIFO and hands
// them to the decoder through a valid/ready handshake. A redirect loads a new
// PC and flushes both the buffered and the in-flight work.
//
// Ports:
//   clock, reset_n                 clock and synchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel (addr == pc)
//   imem_resp_valid/data           fetch response, one per accepted request
//   redirect_valid/pc              one-cycle redirect pulse and its target
//   instr_valid/ready              decoder handshake on the FIFO head
//   instruction, instr_pc          FIFO head word and its PC
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [31:0]       pc, pc_next;
   logic [31:0]       req_pc;
   logic [31:0]       redirect_target;
   logic [CNT_W-1:0]  count, count_next;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [31:0]       fifo_instr [FIFO_DEPTH];
   logic [31:0]       fifo_pc    [FIFO_DEPTH];
   logic              req_fire;
   logic              push;
   logic              pop;

   // Masking keeps every target bit in use while forcing word alignment.
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
   assign imem_req_addr   = pc;

   // Gated by reset_n so the outputs are quiet during the reset cycle itself,
   // before the synchronous clear of count has taken effect.
   assign instr_valid = reset_n && (count != '0);
   assign instruction = fifo_instr[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   // A redirect flushes the FIFO, so a pop in the same cycle is meaningless.
   assign pop      = instr_valid && instr_ready && !redirect_valid;
   assign req_fire = imem_req_valid && imem_req_ready;

   always_comb begin
      state_next     = state;
      pc_next        = pc;
      imem_req_valid = 1'b0;
      push           = 1'b0;
      case (state)
         REQ: begin
            imem_req_valid = reset_n && !redirect_valid && (count < FULL_CNT);
            if (redirect_valid) begin
               pc_next = redirect_target;
            end else if (imem_req_valid && imem_req_ready) begin
               pc_next    = pc + 32'd4;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_next    = redirect_target;
               // Response arriving with the redirect is simply dropped;
               // otherwise it is still owed and must be drained.
               state_next = imem_resp_valid ? REQ : DRAIN;
            end else if (imem_resp_valid) begin
               push       = 1'b1;
               state_next = REQ;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
            end
            if (imem_resp_valid) begin
               state_next = REQ;
            end
         end
         default: begin
            state_next = REQ;
         end
      endcase
   end

   always_comb begin
      count_next = count;
      if (redirect_valid) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Control state: reset applies here only.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= REQ;
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
         if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   // Datapath storage: contents are qualified by count, so no reset needed.
   always_ff @(posedge clock) begin
      if (req_fire) begin
         req_pc <= pc;
      end
      if (push) begin
         fifo_instr[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]    <= req_pc;
      end
   end

endmodule
